// File: rtl/paddle_pkg.sv
// Shared definitions for the breakout paddle path.
// - state_t : paddle movement FSM states
// - dir_t   : direction decoded from the left/right button levels at a frame tick
// - DEF_*   : default screen and paddle geometry, shared with the display and ball logic
package paddle_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOVE_L = 2'd1,
    MOVE_R = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_L    = 2'd1,
    DIR_R    = 2'd2
  } dir_t;

  localparam int unsigned DEF_SCREEN_W = 640;
  localparam int unsigned DEF_SCREEN_H = 480;
  localparam int unsigned DEF_PADDLE_W = 64;
  localparam int unsigned DEF_Y_POS    = 296;

endpackage

// File: rtl/paddle_accel.sv
// Paddle speed ramp. Owns the per-frame speed and the same-direction frame counter.
// Ports:
//   clk      - system clock
//   rst      - asynchronous active-low reset
//   tick     - frame tick
//   same_dir - this tick continues the current movement direction
//   restart  - return speed to SPEED_MIN and clear the counter (any cycle)
//   speed    - pixels per frame to use on the next continuing tick
module paddle_accel #(
  parameter int unsigned SPEED_MIN    = 2,
  parameter int unsigned SPEED_MAX    = 8,
  parameter int unsigned ACCEL_FRAMES = 4,
  parameter int unsigned SPD_W        = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             same_dir,
  input  logic             restart,
  output logic [SPD_W-1:0] speed
);

  localparam int unsigned CNT_W = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCEL_FRAMES - 1);
  localparam logic [SPD_W-1:0] SPD_MIN  = SPD_W'(SPEED_MIN);
  localparam logic [SPD_W-1:0] SPD_MAX  = SPD_W'(SPEED_MAX);

  logic [CNT_W-1:0] accel_cnt;
  logic [CNT_W-1:0] cnt_nxt;

  // The counter runs modulo ACCEL_FRAMES and the entry frame counts as frame one,
  // so speed steps on the frame where the counter lands on its last value: every
  // ACCEL_FRAMES moving frames, with the new speed used from the following frame.
  assign cnt_nxt = (accel_cnt == CNT_LAST) ? '0 : accel_cnt + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      speed     <= SPD_MIN;
      accel_cnt <= '0;
    end else if (restart) begin
      speed     <= SPD_MIN;
      accel_cnt <= '0;
    end else if (tick && same_dir) begin
      accel_cnt <= cnt_nxt;
      if (cnt_nxt == CNT_LAST && speed != SPD_MAX)
        speed <= speed + 1'b1;
    end
  end

endmodule

// File: rtl/paddle_ctrl.sv
// Paddle position controller for the breakout display path.
// Moves the paddle once per frame from debounced left/right levels, ramping speed
// while a direction is held, and clamps at the screen edges. Defining
// PADDLE_WRAP_EN makes the paddle wrap to the opposite edge instead of clamping.
// Ports:
//   clk        - system clock
//   rst        - asynchronous active-low reset
//   frame_tick - one-cycle pulse per frame
//   move_left  - left request level
//   move_right - right request level
//   recenter   - one-cycle request to return to centre (wins over frame_tick)
//   x, y       - paddle top-left corner
//   moving     - x changed on the last frame tick
//   at_left    - x at the left edge
//   at_right   - x at the right edge
module paddle_ctrl
  import paddle_pkg::*;
#(
  parameter int unsigned SCREEN_W     = DEF_SCREEN_W,
  parameter int unsigned PADDLE_W     = DEF_PADDLE_W,
  parameter int unsigned X_W          = 10,
  parameter int unsigned Y_W          = 10,
  parameter int unsigned Y_POS        = DEF_Y_POS,
  parameter int unsigned SPEED_MIN    = 2,
  parameter int unsigned SPEED_MAX    = 8,
  parameter int unsigned ACCEL_FRAMES = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           frame_tick,
  input  logic           move_left,
  input  logic           move_right,
  input  logic           recenter,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           moving,
  output logic           at_left,
  output logic           at_right
);

  localparam int unsigned X_MAX = SCREEN_W - PADDLE_W;
  localparam logic [X_W-1:0] X_MAX_X = X_W'(X_MAX);
  localparam logic [X_W-1:0] X_CTR_X = X_W'(X_MAX / 2);
  localparam logic [X_W:0]   X_MAX_E = (X_W + 1)'(X_MAX);
  localparam logic [X_W-1:0] SMIN_X  = X_W'(SPEED_MIN);

`ifdef PADDLE_WRAP_EN
  localparam logic [X_W-1:0] LEFT_EDGE  = X_MAX_X;
  localparam logic [X_W-1:0] RIGHT_EDGE = '0;
`else
  localparam logic [X_W-1:0] LEFT_EDGE  = '0;
  localparam logic [X_W-1:0] RIGHT_EDGE = X_MAX_X;
`endif

  state_t         state;
  state_t         state_nx;
  dir_t           dir;
  logic           same_dir;
  logic           restart;
  logic [X_W-1:0] speed;
  logic [X_W-1:0] step;
  logic [X_W:0]   x_ext;
  logic [X_W:0]   step_ext;
  logic [X_W-1:0] x_new;

  paddle_accel #(
    .SPEED_MIN    (SPEED_MIN),
    .SPEED_MAX    (SPEED_MAX),
    .ACCEL_FRAMES (ACCEL_FRAMES),
    .SPD_W        (X_W)
  ) u_accel (
    .clk      (clk),
    .rst      (rst),
    .tick     (frame_tick),
    .same_dir (same_dir),
    .restart  (restart),
    .speed    (speed)
  );

  always_comb begin
    dir = DIR_NONE;
    if (move_left && !move_right)
      dir = DIR_L;
    else if (move_right && !move_left)
      dir = DIR_R;
  end

  assign same_dir = (dir == DIR_L && state == MOVE_L) || (dir == DIR_R && state == MOVE_R);
  assign restart  = recenter || (frame_tick && !same_dir);

  // A tick that enters or reverses a direction moves at SPEED_MIN even though the
  // speed register still holds the previous run's value until that same edge.
  assign step     = same_dir ? speed : SMIN_X;
  assign x_ext    = {1'b0, x};
  assign step_ext = {1'b0, step};

  always_comb begin
    state_nx = IDLE;
    x_new    = x;
    unique case (dir)
      DIR_L: begin
        state_nx = MOVE_L;
        if (x_ext < step_ext)
          x_new = LEFT_EDGE;
        else
          x_new = X_W'(x_ext - step_ext);
      end
      DIR_R: begin
        state_nx = MOVE_R;
        if (x_ext > X_MAX_E - step_ext)
          x_new = RIGHT_EDGE;
        else
          x_new = X_W'(x_ext + step_ext);
      end
      default: begin
        state_nx = IDLE;
        x_new    = x;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      x      <= X_CTR_X;
      moving <= 1'b0;
    end else if (recenter) begin
      state  <= IDLE;
      x      <= X_CTR_X;
      moving <= 1'b0;
    end else if (frame_tick) begin
      state  <= state_nx;
      x      <= x_new;
      moving <= (x_new != x);
    end
  end

  assign y        = Y_W'(Y_POS);
  assign at_left  = (x == '0);
  assign at_right = (x == X_MAX_X);

endmodule

// File: tb/tb_paddle_ctrl.sv
module tb_paddle_ctrl;

  localparam int X_MAX = 576;
  localparam int X_CTR = 288;
  localparam int SMIN  = 2;
  localparam int SMAX  = 8;
  localparam int ACC   = 4;
  localparam int YPOS  = 296;
`ifdef PADDLE_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_tick, move_left, move_right, recenter;
  logic [9:0] x, y;
  logic       moving, at_left, at_right;
  logic [22:0] dut_vec;

  int checks   = 0;
  int failures = 0;

  // Reference model: position, held direction (0 none, 1 left, 2 right) and
  // number of consecutive frames held in that direction.
  int m_x   = X_CTR;
  int m_dir = 0;
  int m_n   = 0;
  bit m_mov = 1'b0;

  paddle_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .move_left  (move_left),
    .move_right (move_right),
    .recenter   (recenter),
    .x          (x),
    .y          (y),
    .moving     (moving),
    .at_left    (at_left),
    .at_right   (at_right)
  );

  always #5 clk = ~clk;

  assign dut_vec = {x, moving, at_left, at_right, y};

  function automatic logic [22:0] exp_vec();
    return {10'(m_x), m_mov, (m_x == 0), (m_x == X_MAX), 10'(YPOS)};
  endfunction

  task automatic model_reset();
    m_x = X_CTR; m_dir = 0; m_n = 0; m_mov = 1'b0;
  endtask

  task automatic model_clk(input bit tk, input bit l, input bit r, input bit rc);
    int d, sp, nx;
    if (rc) begin
      model_reset();
    end else if (tk) begin
      d = (l && !r) ? 1 : ((r && !l) ? 2 : 0);
      if (d == 0) begin
        m_dir = 0; m_n = 0; m_mov = 1'b0;
      end else begin
        m_n   = (d == m_dir) ? m_n + 1 : 1;
        m_dir = d;
        sp = SMIN + (m_n - 1) / ACC;
        if (sp > SMAX) sp = SMAX;
        nx = (d == 1) ? m_x - sp : m_x + sp;
        if (nx < 0)     nx = WRAP ? X_MAX : 0;
        if (nx > X_MAX) nx = WRAP ? 0 : X_MAX;
        m_mov = (nx != m_x);
        m_x   = nx;
      end
    end
  endtask

  task automatic cycle(input bit tk, input bit l, input bit r, input bit rc);
    @(negedge clk);
    frame_tick = tk; move_left = l; move_right = r; recenter = rc;
    @(posedge clk);
    model_clk(tk, l, r, rc);
    #1;
    frame_tick = 1'b0; recenter = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; frame_tick = 0; move_left = 0; move_right = 0; recenter = 0;
    model_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (dut_vec !== exp_vec()) begin
      failures++;
      $display("FAIL reset_state got=%h want=%h", dut_vec, exp_vec());
    end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b1, 1'b0, 1'b0);
    end
    checks++;
    if (x !== 10'd288 || moving !== 1'b0 || at_left !== 1'b0 || at_right !== 1'b0) begin
      failures++;
      $display("FAIL idle_ticks got x=%0d mv=%0b al=%0b ar=%0b want x=288 mv=0 al=0 ar=0",
               x, moving, at_left, at_right);
    end
  endtask

  task automatic test_move_right();
    int seq[10] = '{290, 292, 294, 296, 299, 302, 305, 308, 312, 316};
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b0, 1'b1, 1'b0);
      checks++;
      if (x !== 10'(seq[i]) || dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL move_right[%0d] got x=%0d vec=%h want x=%0d vec=%h", i, x, dut_vec, seq[i], exp_vec());
      end
      // non-tick cycles must hold every register
      repeat ($urandom_range(2)) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    end
    checks++;
    if (dut_vec !== exp_vec()) begin
      failures++;
      $display("FAIL hold_no_tick got=%h want=%h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_left_wall();
    int guard = 0;
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    while (m_x != 0 && guard < 300) begin
      cycle(1'b1, 1'b1, 1'b0, 1'b0);
      guard++;
      if (m_x != 0 && WRAP && m_x > X_CTR) break;
    end
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    // return to x=0 via centre if wrapping, then step to x=3
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 300 && m_x != 0; i++) cycle(1'b1, m_x >= SMIN, m_x < SMIN, 1'b0);
    checks++;
    if (x !== 10'd0) begin
      failures++;
      $display("FAIL reach_left got x=%0d want x=0", x);
    end
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
    end
    checks++;
    if (x !== 10'd3) begin
      failures++;
      $display("FAIL setup_x3 got x=%0d want x=3", x);
    end
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (x !== 10'd1 || moving !== 1'b1) begin
      failures++;
      $display("FAIL left_to_1 got x=%0d mv=%0b want x=1 mv=1", x, moving);
    end
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (x !== (WRAP ? 10'd576 : 10'd0) || moving !== 1'b1 || at_left !== !WRAP || at_right !== WRAP) begin
      failures++;
      $display("FAIL left_edge got x=%0d mv=%0b al=%0b ar=%0b want x=%0d mv=1",
               x, moving, at_left, at_right, WRAP ? 576 : 0);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 1'b0);
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL past_edge[%0d] got=%h want=%h", i, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_reverse();
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0);
    checks++;
    if (x !== 10'd308) begin
      failures++;
      $display("FAIL right8 got x=%0d want x=308", x);
    end
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (x !== 10'd306 || moving !== 1'b1) begin
      failures++;
      $display("FAIL reverse_step got x=%0d mv=%0b want x=306 mv=1", x, moving);
    end
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    checks++;
    if (x !== 10'd306 || moving !== 1'b0) begin
      failures++;
      $display("FAIL both_pressed got x=%0d mv=%0b want x=306 mv=0", x, moving);
    end
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    checks++;
    if (x !== 10'd308) begin
      failures++;
      $display("FAIL idle_restart got x=%0d want x=308", x);
    end
  endtask

  task automatic test_recenter_tick();
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 37; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0);
    checks++;
    if (x !== 10'd500) begin
      failures++;
      $display("FAIL reach_500 got x=%0d want x=500", x);
    end
    cycle(1'b1, 1'b0, 1'b1, 1'b1);
    checks++;
    if (x !== 10'd288 || moving !== 1'b0) begin
      failures++;
      $display("FAIL recenter_tick got x=%0d mv=%0b want x=288 mv=0", x, moving);
    end
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    checks++;
    if (x !== 10'd290) begin
      failures++;
      $display("FAIL after_recenter got x=%0d want x=290", x);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    checks++;
    if (x !== 10'd288 || moving !== 1'b0 || dut_vec !== exp_vec()) begin
      failures++;
      $display("FAIL async_reset got x=%0d mv=%0b want x=288 mv=0", x, moving);
    end
    @(negedge clk);
    rst = 1'b1;
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    checks++;
    if (x !== 10'd290) begin
      failures++;
      $display("FAIL post_reset_move got x=%0d want x=290", x);
    end
  endtask

  task automatic test_random();
    bit l = 1'b0;
    bit r = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) l = 1'($urandom_range(1));
      if ($urandom_range(7) == 0) r = 1'($urandom_range(1));
      cycle($urandom_range(2) == 0, l, r, $urandom_range(59) == 0);
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL random[%0d] got x=%0d vec=%h want x=%0d vec=%h", i, x, dut_vec, m_x, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_move_right();
    test_left_wall();
    test_reverse();
    test_recenter_tick();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
